// File: rtl/pea_ctx_sequencer_pkg.sv
// pea_pkg: shared PEA geometry, context-count width and sequencer state type
package pea_pkg;
  localparam int N = 4;
  localparam int M = 4;
  localparam int N_CFG_REGS_PE = 8;
  localparam int CTX_W = $clog2(N_CFG_REGS_PE) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} ctx_seq_state_e;
endpackage

// File: rtl/pea_ctx_shadow.sv
// pea_ctx_shadow: shadow copy of the per-PE config words with per-PE word select by context
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : capture cfg_i into the shadow
//   cfg_i          : words packed [N][M][N_CFG_REGS_PE][32]
//   ctx_i          : word index selected for every PE
//   en_i           : drive the selected words, else zeros
//   cfg_o          : selected word per PE packed [N][M][32]
module pea_ctx_shadow
  import pea_pkg::*;
#(
  parameter int N = pea_pkg::N,
  parameter int M = pea_pkg::M,
  parameter int N_CFG_REGS_PE = pea_pkg::N_CFG_REGS_PE
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               load_i,
  input  logic [N*M*N_CFG_REGS_PE*32-1:0]    cfg_i,
  input  logic [$clog2(N_CFG_REGS_PE)-1:0]   ctx_i,
  input  logic                               en_i,
  output logic [N*M*32-1:0]                  cfg_o
);
  logic [N*M*N_CFG_REGS_PE*32-1:0] shadow;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) shadow <= '0;
    else if (load_i) shadow <= cfg_i;
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < M; c++) begin : g_col
      logic [N_CFG_REGS_PE-1:0][31:0] words;
      assign words = shadow[(r*M+c)*N_CFG_REGS_PE*32 +: N_CFG_REGS_PE*32];
      assign cfg_o[(r*M+c)*32 +: 32] = en_i ? words[ctx_i] : '0;
    end
  end
endmodule

// File: rtl/pea_ctx_sequencer.sv
// pea_ctx_sequencer: shadows PEA config words on start and steps a context index over n_ctx words for n_iter iterations
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   reg_cfg_pea_i       : config words packed [N][M][N_CFG_REGS_PE][32]
//   n_ctx_i, n_iter_i   : contexts per iteration (clamped to N_CFG_REGS_PE), iteration count
//   start_i, abort_i    : start pulse (IDLE only), synchronous abort (wins over start)
//   stall_i             : stream back-pressure, holds the sequence
//   cfg_pe_o            : current word per PE packed [N][M][32], zero outside RUN
//   ctx_idx_o, pe_en_o  : current context index, PEs advance this cycle
//   busy_o, done_o      : sequence active, one-cycle completion pulse
//   stall_cnt_o         : stalled RUN cycles, only with MAGE_CTX_SEQ_STALL_CNT_EN defined
module pea_ctx_sequencer
  import pea_pkg::*;
#(
  parameter int N = pea_pkg::N,
  parameter int M = pea_pkg::M,
  parameter int N_CFG_REGS_PE = pea_pkg::N_CFG_REGS_PE,
  parameter int ITER_W = 16,
  localparam int CTX_W = $clog2(N_CFG_REGS_PE) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [N*M*N_CFG_REGS_PE*32-1:0] reg_cfg_pea_i,
  input  logic [CTX_W-1:0]                n_ctx_i,
  input  logic [ITER_W-1:0]               n_iter_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic                            stall_i,
  output logic [N*M*32-1:0]               cfg_pe_o,
  output logic [CTX_W-2:0]                ctx_idx_o,
  output logic                            pe_en_o,
  output logic                            busy_o,
  output logic                            done_o
`ifdef MAGE_CTX_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                     stall_cnt_o
`endif
);
  ctx_seq_state_e state;
  logic [CTX_W-2:0] ctx;
  logic [ITER_W-1:0] iter, n_iter;
  logic [CTX_W-1:0] n_ctx, n_ctx_clamp;
  logic run, load, last_ctx, last_iter;
  assign run = state == RUN;
  assign load = state == IDLE && start_i && !abort_i;
  assign n_ctx_clamp = n_ctx_i > CTX_W'(N_CFG_REGS_PE) ? CTX_W'(N_CFG_REGS_PE) : n_ctx_i;
  assign last_ctx = {1'b0, ctx} + CTX_W'(1) == n_ctx;
  assign last_iter = iter + ITER_W'(1) == n_iter;
  assign busy_o = run;
  assign pe_en_o = run && !stall_i;
  assign done_o = state == DONE;
  assign ctx_idx_o = run ? ctx : '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      ctx <= '0;
      iter <= '0;
      n_ctx <= '0;
      n_iter <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      ctx <= '0;
      iter <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          n_ctx <= n_ctx_clamp;
          n_iter <= n_iter_i;
          ctx <= '0;
          iter <= '0;
          state <= (n_ctx_i == '0 || n_iter_i == '0) ? DONE : RUN;
        end
        RUN: if (!stall_i) begin
          ctx <= last_ctx ? '0 : ctx + (CTX_W-1)'(1);
          if (last_ctx) begin
            iter <= last_iter ? '0 : iter + ITER_W'(1);
            if (last_iter) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  pea_ctx_shadow #(.N(N), .M(M), .N_CFG_REGS_PE(N_CFG_REGS_PE)) u_shadow (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .load_i(load),
    .cfg_i(reg_cfg_pea_i),
    .ctx_i(ctx),
    .en_i(run),
    .cfg_o(cfg_pe_o)
  );
`ifdef MAGE_CTX_SEQ_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) stall_cnt_o <= '0;
    else if (load) stall_cnt_o <= '0;
    else if (run && stall_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
`endif
endmodule

// File: tb/tb_pea_ctx_sequencer.sv
// tb_pea_ctx_sequencer: randomized scoreboard bench for pea_ctx_sequencer
module tb_pea_ctx_sequencer;
  localparam int N = 4, M = 4, NC = 8, IW = 16, CW = 4;
  typedef struct {
    logic [CW-2:0] ctx;
    logic [N-1:0][M-1:0][31:0] cfg;
  } beat_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, stall = 0;
  logic [N-1:0][M-1:0][NC-1:0][31:0] regs = '0;
  logic [CW-1:0] n_ctx = '0;
  logic [IW-1:0] n_iter = '0;
  logic [N-1:0][M-1:0][31:0] cfg;
  logic [CW-2:0] ctx_idx;
  logic pe_en, busy, done;
`ifdef MAGE_CTX_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  beat_t exp_q[$];
  int checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0;

  pea_ctx_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .reg_cfg_pea_i(regs), .n_ctx_i(n_ctx), .n_iter_i(n_iter),
    .start_i(start), .abort_i(abort), .stall_i(stall), .cfg_pe_o(cfg), .ctx_idx_o(ctx_idx),
    .pe_en_o(pe_en), .busy_o(busy), .done_o(done)
`ifdef MAGE_CTX_SEQ_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every busy cycle must present the scoreboard head; advancing cycles consume it.
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      chk("busy_not_done", 512'(done), 512'(0));
      chk("pe_en_vs_stall", 512'(pe_en), 512'(!stall));
      if (exp_q.size() == 0) chk("unexpected_busy", 512'(busy), 512'(0));
      else begin
        chk("ctx_idx", 512'(ctx_idx), 512'(exp_q[0].ctx));
        chk("cfg_pe", 512'(cfg), 512'(exp_q[0].cfg));
        if (pe_en) void'(exp_q.pop_front());
      end
    end else
      chk("idle_outputs", {cfg, 32'(ctx_idx), 32'(pe_en)}, '0);
    if (done) done_cnt++;
  end

  // Reference: the expected sequence is every iteration sweeping words 0..min(n_ctx,NC)-1.
  function automatic int push_model(input int nc, input int ni);
    int ne = nc > NC ? NC : nc;
    beat_t b;
    for (int it = 0; it < ni; it++)
      for (int k = 0; k < ne; k++) begin
        b.ctx = (CW-1)'(k);
        for (int r = 0; r < N; r++)
          for (int c = 0; c < M; c++) b.cfg[r][c] = regs[r][c][k];
        exp_q.push_back(b);
      end
    return ne * ni;
  endfunction

  task automatic fill_regs(input bit structured);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++)
        for (int k = 0; k < NC; k++)
          regs[r][c][k] = structured ? 32'((r << 16) | (c << 8) | k) : $urandom;
  endtask

  // Runs one sequence; stall_at/stall_len forces a stall burst at a given beat, sp is a random stall percentage.
  task automatic run(input int nc, input int ni, input int sp, input int stall_at, input int stall_len, input bit iso, input string tag);
    int rem, stalls = 0, held = 0, cyc = 0;
    bit st;
    busy_cnt = 0;
    done_cnt = 0;
    n_ctx = CW'(nc);
    n_iter = IW'(ni);
    start = 1;
    rem = push_model(nc, ni);
    @(posedge clk); #1;
    start = 0;
    while (rem > 0 && cyc < 5000) begin
      st = ($urandom_range(99) < sp);
      if ((rem == nc * ni - stall_at) && held < stall_len) begin st = 1; held++; end
      stall = st;
      if (iso && cyc == 2) begin
        fill_regs(0);
        n_ctx = CW'(1);
        start = 1;
      end
      @(posedge clk); #1;
      start = 0;
      if (st) stalls++; else rem--;
      cyc++;
    end
    stall = 0;
    chk({tag, "_in_done"}, 512'(done), 512'(1));
    @(posedge clk); #1;
    chk({tag, "_done_cnt"}, 512'(done_cnt), 512'(1));
    chk({tag, "_busy_cycles"}, 512'(busy_cnt), 512'(rem + (nc > NC ? NC : nc) * ni + stalls));
    chk({tag, "_queue_drained"}, 512'(exp_q.size()), 512'(0));
`ifdef MAGE_CTX_SEQ_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, 512'(stall_cnt), 512'(stalls));
`endif
  endtask

  initial begin
    #12;
    chk("reset_busy", 512'(busy), 512'(0));
    chk("reset_done", 512'(done), 512'(0));
    rst_n = 1;
    @(posedge clk); #1;
    fill_regs(1);
    run(3, 2, 0, -1, 0, 0, "basic");
    run(3, 2, 0, 1, 4, 0, "stall_hold");
    run(0, 2, 0, -1, 0, 0, "zero_ctx");
    run(3, 0, 0, -1, 0, 0, "zero_iter");
    fill_regs(0);
    run(5, 3, 0, -1, 0, 1, "isolation");
    fill_regs(0);
    run(12, 2, 20, -1, 0, 0, "clamp");
    for (int i = 0; i < 6; i++) begin
      fill_regs(0);
      run($urandom_range(8), $urandom_range(3), 30, -1, 0, 0, "random");
    end
    // Abort at iteration 1, context 2 of a 4x3 run.
    fill_regs(0);
    busy_cnt = 0;
    done_cnt = 0;
    n_ctx = 4;
    n_iter = 3;
    start = 1;
    void'(push_model(4, 3));
    @(posedge clk); #1;
    start = 0;
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_ctx_before", 512'(ctx_idx), 512'(2));
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete();
    chk("abort_idle", {cfg, 32'(busy), 32'(ctx_idx), 32'(pe_en)}, '0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_done", 512'(done_cnt), 512'(0));
    chk("abort_busy_cycles", 512'(busy_cnt), 512'(7));
    fill_regs(1);
    run(4, 1, 0, -1, 0, 0, "rerun");
    // Abort in IDLE wins over start.
    n_ctx = 2;
    n_iter = 1;
    start = 1;
    abort = 1;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 0;
    abort = 0;
    @(posedge clk); #1;
    chk("idle_abort_busy", 512'(busy), 512'(0));
    chk("idle_abort_done", 512'(done_cnt), 512'(0));
    // Asynchronous reset in the middle of a run.
    fill_regs(0);
    n_ctx = 5;
    n_iter = 2;
    start = 1;
    void'(push_model(5, 2));
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    exp_q.delete();
    chk("areset_outputs", {cfg, 32'(busy), 32'(ctx_idx), 32'(pe_en)}, '0);
    done_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) begin @(posedge clk); #1; end
    chk("areset_no_done", 512'(done_cnt), 512'(0));
    chk("areset_idle", 512'(busy), 512'(0));
    run(2, 2, 0, -1, 0, 0, "post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
